// File: rtl/axil_req_arbiter.sv
// Two-requester front end for a single AXI4-Lite master port.
// A round-robin arbiter picks one requester, latches its transaction and
// runs it to completion on the AXI4-Lite port before accepting another.
// Only one AXI transaction is ever outstanding.
module axil_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                req,
  input  logic [1:0]                we,
  input  logic [2*ADDR_W-1:0]       addr,
  input  logic [2*DATA_W-1:0]       wdata,
  input  logic [2*(DATA_W/8)-1:0]   wstrb,
  output logic [1:0]                done,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                resp,
  output logic                      busy,
  output logic [ADDR_W-1:0]         awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W/8-1:0]       m_wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [ADDR_W-1:0]         araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;

  // Last-granted requester; starts at 1 so requester 0 wins the first tie.
  logic                last_gnt;
  logic                win;

  // Latched transaction of the granted requester.
  logic                lat_gnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;

  // Per-channel "valid still waiting for ready" flags; they are the valids.
  logic                aw_pend;
  logic                w_pend;
  logic                ar_pend;

  logic                grant;

  assign grant   = (state_q == IDLE) && (|req);

  assign awaddr  = lat_addr;
  assign araddr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign m_wstrb = lat_wstrb;
  assign awvalid = aw_pend;
  assign wvalid  = w_pend;
  assign arvalid = ar_pend;

  // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_gnt;
      default: win = 1'b0;
    endcase
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 2'b00;
    bready  = 1'b0;
    rready  = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (|req) state_d = ADDR;
      end
      ADDR: begin
        if (lat_we) begin
          // Both channels must have handshaken, possibly in this very cycle.
          if ((!aw_pend || awready) && (!w_pend || wready)) state_d = RESP;
        end else begin
          if (!ar_pend || arready) state_d = RESP;
        end
      end
      RESP: begin
        bready = lat_we;
        rready = !lat_we;
        if (lat_we ? bvalid : rvalid) state_d = DONE;
      end
      DONE: begin
        done    = lat_gnt ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant pointer and latched payload; captured only on a grant so later
  // input changes cannot disturb the transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt  <= 1'b1;
      lat_gnt   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (grant) begin
      last_gnt  <= win;
      lat_gnt   <= win;
      lat_we    <= we[win];
      lat_addr  <= win ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
      lat_wdata <= win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      lat_wstrb <= win ? wstrb[2*STRB_W-1:STRB_W] : wstrb[STRB_W-1:0];
    end
  end

  // Channel valids: raised on entry to ADDR, each dropped on its own handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
    end else if (grant) begin
      aw_pend <= we[win];
      w_pend  <= we[win];
      ar_pend <= !we[win];
    end else begin
      if (aw_pend && awready) aw_pend <= 1'b0;
      if (w_pend && wready)   w_pend  <= 1'b0;
      if (ar_pend && arready) ar_pend <= 1'b0;
    end
  end

  // Response capture; rdata only updates on reads, both hold until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      resp  <= 2'b00;
    end else if (state_q == RESP) begin
      if (lat_we && bvalid) begin
        resp <= bresp;
      end else if (!lat_we && rvalid) begin
        resp  <= rresp;
        rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter with a small AXI4-Lite slave whose
// ready/response delays are set per test. Read data returned by the slave
// is the read address XOR 0xDEAD0000.
module tb_axil_req_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        busy;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] m_rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;

  axil_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .done(done), .rdata(rdata), .resp(resp), .busy(busy),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .m_rdata(m_rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] cfg_bresp = 2'b00;
  logic [1:0] cfg_rresp = 2'b00;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_seen, w_seen, bpend, rpend;
  logic [31:0] rd_val;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bvalid  = bpend && (b_cnt >= b_dly);
  assign rvalid  = rpend && (r_cnt >= r_dly);
  assign bresp   = cfg_bresp;
  assign rresp   = cfg_rresp;
  assign m_rdata = rd_val;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; bpend <= 1'b0; rpend <= 1'b0;
      rd_val <= 32'h0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) aw_seen <= 1'b1;
      if (wvalid && wready)   w_seen  <= 1'b1;
      if (!bpend && (aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
        bpend <= 1'b1;
        b_cnt <= 0;
      end else if (bpend && b_cnt < b_dly) begin
        b_cnt <= b_cnt + 1;
      end
      if (bvalid && bready) begin
        bpend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
      end
      if (arvalid && arready) begin
        rpend  <= 1'b1;
        r_cnt  <= 0;
        rd_val <= araddr ^ 32'hDEAD0000;
      end else if (rpend && r_cnt < r_dly) begin
        r_cnt <= r_cnt + 1;
      end
      if (rvalid && rready) rpend <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until done is seen, or -1 if it never came.
  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done != 2'b00) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp_done [4];
    logic [31:0] exp_rd [4];
    exp_done[0] = 2'b01; exp_done[1] = 2'b10; exp_done[2] = 2'b01; exp_done[3] = 2'b10;
    exp_rd[0] = 32'hDEAD0100; exp_rd[1] = 32'hDEAD0200;
    exp_rd[2] = 32'hDEAD0100; exp_rd[3] = 32'hDEAD0200;

    reset = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; wstrb = '0;
    #1;
    // Reset values
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", resp, 0);
    chk("rst_awaddr", awaddr, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single zero-wait write from requester 0
    req = 2'b01; we = 2'b01; addr[31:0] = 32'h10; wdata[31:0] = 32'hA5A5A5A5; wstrb[3:0] = 4'hF;
    chk("w0_c0_busy", busy, 0);
    tick();
    chk("w0_c1_awvalid", awvalid, 1);
    chk("w0_c1_wvalid", wvalid, 1);
    chk("w0_c1_awaddr", awaddr, 32'h10);
    chk("w0_c1_wdata", m_wdata, 32'hA5A5A5A5);
    chk("w0_c1_wstrb", m_wstrb, 4'hF);
    chk("w0_c1_busy", busy, 1);
    req = 2'b00; addr[31:0] = 32'h99;
    tick();
    chk("w0_c2_awvalid", awvalid, 0);
    chk("w0_c2_wvalid", wvalid, 0);
    chk("w0_c2_bready", bready, 1);
    chk("w0_c2_awaddr", awaddr, 32'h10);
    chk("w0_c2_done", done, 0);
    tick();
    chk("w0_c3_done", done, 2'b01);
    chk("w0_c3_resp", resp, 2'b00);
    tick();
    chk("w0_c4_done", done, 0);
    chk("w0_c4_busy", busy, 0);

    // Reset restores the pointer, then both requesters read continuously
    reset = 1'b0;
    tick();
    chk("rr_rst_busy", busy, 0);
    reset = 1'b1;
    we = 2'b00; addr = {32'h200, 32'h100}; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      chk("rr_lat", n, (i == 0) ? 3 : 4);
      chk("rr_done", done, exp_done[i]);
      chk("rr_rdata", rdata, exp_rd[i]);
      chk("rr_resp", resp, 2'b00);
      if (i == 3) req = 2'b00;
    end
    tick();
    chk("rr_idle_busy", busy, 0);

    // Write from requester 1 with wready three cycles after awready
    w_dly = 3; cfg_bresp = 2'b01;
    req = 2'b10; we = 2'b10; addr[63:32] = 32'h44; wdata[63:32] = 32'h12345678; wstrb[7:4] = 4'h3;
    tick();
    chk("ws_c1_awvalid", awvalid, 1);
    chk("ws_c1_wvalid", wvalid, 1);
    chk("ws_c1_awaddr", awaddr, 32'h44);
    chk("ws_c1_wdata", m_wdata, 32'h12345678);
    chk("ws_c1_wstrb", m_wstrb, 4'h3);
    req = 2'b00; addr[63:32] = 32'hFFFF; wdata[63:32] = 32'h0;
    tick();
    chk("ws_c2_awvalid", awvalid, 0);
    chk("ws_c2_wvalid", wvalid, 1);
    chk("ws_c2_awaddr", awaddr, 32'h44);
    tick();
    chk("ws_c3_wvalid", wvalid, 1);
    chk("ws_c3_done", done, 0);
    tick();
    chk("ws_c4_wvalid", wvalid, 1);
    chk("ws_c4_wdata", m_wdata, 32'h12345678);
    tick();
    chk("ws_c5_wvalid", wvalid, 0);
    chk("ws_c5_bready", bready, 1);
    chk("ws_c5_done", done, 0);
    tick();
    chk("ws_c6_done", done, 2'b10);
    chk("ws_c6_resp", resp, 2'b01);
    chk("ws_c6_rdata", rdata, 32'hDEAD0200);
    tick();
    chk("ws_c7_done", done, 0);
    chk("ws_c7_busy", busy, 0);

    // Read with SLVERR and rvalid five cycles into RESP
    w_dly = 0; cfg_rresp = 2'b10; r_dly = 5;
    req = 2'b01; we = 2'b00; addr[31:0] = 32'h80;
    tick();
    chk("rs_c1_arvalid", arvalid, 1);
    chk("rs_c1_araddr", araddr, 32'h80);
    req = 2'b00;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rs_rready", rready, 1);
      chk("rs_done", done, 0);
    end
    tick();
    chk("rs_done_pulse", done, 2'b01);
    chk("rs_resp", resp, 2'b10);
    chk("rs_rdata", rdata, 32'hDEAD0080);
    tick();
    chk("rs_done_end", done, 0);

    // Reset during RESP, then the still-pending request is served
    cfg_rresp = 2'b00;
    req = 2'b10; we = 2'b00; addr[63:32] = 32'h300;
    tick();
    tick();
    chk("ra_c2_rready", rready, 1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("ra_busy", busy, 0);
    chk("ra_rready", rready, 0);
    chk("ra_arvalid", arvalid, 0);
    chk("ra_done", done, 0);
    chk("ra_rdata", rdata, 0);
    chk("ra_resp", resp, 0);
    chk("ra_araddr", araddr, 0);
    tick();
    chk("ra_hold_done", done, 0);
    r_dly = 0;
    reset = 1'b1;
    wait_done(n);
    chk("ra_lat", n, 3);
    chk("ra_done_pulse", done, 2'b10);
    chk("ra_rdata_new", rdata, 32'hDEAD0300);
    chk("ra_resp_new", resp, 2'b00);
    req = 2'b00;
    tick();
    chk("ra_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_req_arbiter.md
AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of both requesters and the AXI4-Lite master port.
REQ-002 Parameter: DATA_W, default 32, data width; WSTRB width is DATA_W/8.
REQ-003 Port: clk  in  1  sole clock; all logic rising-edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: req  in  2  per-requester transaction request; bit i = requester i.
REQ-006 Port: we  in  2  per-requester write (1) / read (0) select.
REQ-007 Port: addr  in  2*ADDR_W  requester addresses; requester i occupies slice i.
REQ-008 Port: wdata  in  2*DATA_W  requester write data, sliced per requester.
REQ-009 Port: wstrb  in  2*DATA_W/8  requester byte strobes, sliced per requester.
REQ-010 Port: done  out  2  one-cycle completion pulse per requester.
REQ-011 Port: rdata  out  DATA_W  read data of the last completed read.
REQ-012 Port: resp  out  2  AXI response of the last completed transaction.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.
REQ-014 Port: awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AXI4-Lite write address channel.
REQ-015 Port: m_wdata/m_wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  AXI4-Lite write data channel.
REQ-016 Port: bresp/bvalid/bready  in/in/out  2/1/1  AXI4-Lite write response channel.
REQ-017 Port: araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AXI4-Lite read address channel.
REQ-018 Port: m_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  AXI4-Lite read data channel.

Function
REQ-019 FSM states: IDLE, ADDR, RESP, DONE; exactly one AXI transaction outstanding at any time.
REQ-020 IDLE: if any req bit is set, latch the winner's we/addr/wdata/wstrb and go to ADDR the next cycle; otherwise stay.
REQ-021 Arbitration is round-robin with a last-grant pointer: single requester always wins; with both requesting, the one not granted last wins.
REQ-022 Pointer resets to 1, so requester 0 wins the first contention after reset; the pointer updates only on grant.
REQ-023 ADDR, write: awvalid and wvalid both assert on ADDR entry; each deasserts on its own ready handshake; go to RESP in the cycle both have handshaken, including the same cycle.
REQ-024 ADDR, read: arvalid asserts; go to RESP on arvalid&arready.
REQ-025 Payload outputs (awaddr/araddr/m_wdata/m_wstrb) hold the latched values and never change while the corresponding valid is high.
REQ-026 RESP: bready (write) or rready (read) is high; on the bvalid or rvalid handshake, capture bresp or rresp into resp, capture m_rdata into rdata (reads only), and go to DONE.
REQ-027 DONE: done[granted]=1 for exactly one cycle, then return to IDLE; the earliest next grant is the cycle after DONE.
REQ-028 rdata and resp hold their values until the next capture; rdata is unchanged by writes.
REQ-029 Minimum latency from req to done is 4 cycles, with zero-wait-state slave readies.
REQ-030 Deassertion of req, or a change in inputs, after grant has no effect; the latched transaction completes.
REQ-031 A requester holding req after its done is eligible again and obeys round-robin.

Reset
REQ-032 On reset low, asynchronously: state=IDLE, pointer=1; all valids/readies, done, and busy =0; rdata=0, resp=2'b00; latched payload=0.
REQ-033 Reset asserted mid-transaction aborts it immediately; no done is issued for the aborted transaction.

Verification
REQ-034 req=2'b01, we=1, addr0=0x10, wdata0=0xA5A5A5A5, wstrb0=0xF, zero-wait slave -> awaddr=0x10 and m_wdata=0xA5A5A5A5 handshake, done=2'b01 four cycles after req, resp=2'b00.
REQ-035 req=2'b11 held, both reads -> grants alternate 0,1,0,1; rdata in each done cycle matches the slave data for that address.
REQ-036 Write with awready 3 cycles before wready -> awvalid drops after its handshake, wvalid holds until its own; one done only.
REQ-037 Read with rresp=2'b10 and rvalid delayed 5 cycles -> rready high throughout RESP, resp=2'b10, rdata captured, done one cycle.
REQ-038 Reset low during RESP -> all outputs return to reset values that cycle, no done; after release, the pending req is granted normally.
